// File: rtl/alu_exec_unit.sv
// Sequential ALU execution unit: latches operands/opcode on load, completes single-cycle ops
// in one edge and MUL through a WIDTH-edge shift-add loop, then reports result, zero and overflow.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_MUL  = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    state_e             state, state_next;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc, mcand, acc_next, shl_full;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               capture, mul_last, complete;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_ovf;

    assign busy     = (state != S_IDLE);
    assign capture  = load && (state == S_IDLE);
    assign mul_last = (state == S_MUL) && (cnt == CW'(1));
    assign complete = (state == S_EXEC) || mul_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (load) begin
                    state_next = (op_e'(op) == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC:  state_next = S_IDLE;
            S_MUL:   if (cnt == CW'(1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // MUL completes on the same edge as its last accumulate, so results use acc_next
    always_comb begin
        alu_r    = '0;
        alu_ovf  = 1'b0;
        acc_next = mplier[0] ? (acc + mcand) : acc;
        shl_full = {{WIDTH{1'b0}}, a_q} << b_q[SHW-1:0];
        case (op_q)
            OP_ADD: begin
                alu_r   = a_q + b_q;
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_r   = a_q - b_q;
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_r[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_r = a_q & b_q;
            OP_OR:   alu_r = a_q | b_q;
            OP_XOR:  alu_r = a_q ^ b_q;
            OP_SHL: begin
                alu_r   = shl_full[WIDTH-1:0];
                alu_ovf = |shl_full[2*WIDTH-1:WIDTH];
            end
            OP_MUL: begin
                alu_r   = acc_next[WIDTH-1:0];
                alu_ovf = |acc_next[2*WIDTH-1:WIDTH];
            end
            OP_PASS: alu_r = a_q;
            default: alu_r = a_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (capture) begin
                a_q    <= a;
                b_q    <= b;
                op_q   <= op_e'(op);
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                cnt    <= CW'(WIDTH);
            end
            if (state == S_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end
            if (complete) begin
                result   <= alu_r;
                overflow <= alu_ovf;
                zero     <= (alu_r == '0);
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit at WIDTH=8.
module tb_alu_exec_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [2:0] op;
    logic [7:0] a, b;
    logic       busy, done, overflow, zero;
    logic [7:0] result;

    int tests = 0;
    int fails = 0;

    alu_exec_unit #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        load = 1'b1;
        op   = o;
        a    = x;
        b    = y;
        tick();
        load = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [7:0] r, input logic v, input logic z);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_result"}, {24'd0, result}, {24'd0, r});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, v});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, z});
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        op   = 3'b000;
        a    = 8'h00;
        b    = 8'h00;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: signed overflow on ADD
        start(3'b000, 8'h7F, 8'h01);
        check("add_cap_busy", {31'd0, busy}, 32'd1);
        check("add_cap_done", {31'd0, done}, 32'd0);
        tick();
        check_done("add7f", 8'h80, 1'b1, 1'b0);
        tick();
        check("add_done_pulse", {31'd0, done}, 32'd0);

        // 2: zero results
        start(3'b001, 8'h05, 8'h05);
        tick();
        check_done("sub_eq", 8'h00, 1'b0, 1'b1);
        start(3'b000, 8'h80, 8'h80);
        tick();
        check_done("add80", 8'h00, 1'b1, 1'b1);

        // 3: MUL latency and high-half overflow
        start(3'b110, 8'h0F, 8'h11);
        for (int i = 0; i < 7; i++) begin
            check("mul_busy", {31'd0, busy}, 32'd1);
            check("mul_nodone", {31'd0, done}, 32'd0);
            check("mul_hold", {24'd0, result}, 32'd0);
            tick();
        end
        check("mul_busy_last", {31'd0, busy}, 32'd1);
        tick();
        check_done("mul_0f11", 8'hFF, 1'b0, 1'b0);
        start(3'b110, 8'h10, 8'h10);
        repeat (7) tick();
        check("mul2_busy", {31'd0, busy}, 32'd1);
        tick();
        check_done("mul_1010", 8'h00, 1'b1, 1'b1);

        // 4: load during MUL must be ignored
        start(3'b110, 8'h03, 8'h05);
        repeat (3) tick();
        load = 1'b1;
        op   = 3'b000;
        a    = 8'h01;
        b    = 8'h01;
        tick();
        load = 1'b0;
        repeat (3) tick();
        check("mul_ign_busy", {31'd0, busy}, 32'd1);
        check("mul_ign_hold", {24'd0, result}, 32'd0);
        tick();
        check_done("mul_0305", 8'h0F, 1'b0, 1'b0);
        tick();
        check("mul_ign_idle_busy", {31'd0, busy}, 32'd0);
        check("mul_ign_idle_done", {31'd0, done}, 32'd0);

        // 5: async reset mid-MUL, between edges
        start(3'b110, 8'h0F, 8'h11);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", {24'd0, result}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_idle", {31'd0, busy}, 32'd0);
        start(3'b000, 8'h02, 8'h03);
        tick();
        check_done("add_post_rst", 8'h05, 1'b0, 1'b0);

        // 6: SHL overflow, then back-to-back load in the done cycle
        start(3'b101, 8'h81, 8'h01);
        tick();
        check_done("shl81", 8'h02, 1'b1, 1'b0);
        start(3'b111, 8'hA5, 8'h00);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_nodone", {31'd0, done}, 32'd0);
        check("b2b_hold", {24'd0, result}, 32'h02);
        tick();
        check_done("pass_a5", 8'hA5, 1'b0, 1'b0);

        // remaining bitwise ops
        start(3'b010, 8'hF0, 8'h3C);
        tick();
        check_done("and", 8'h30, 1'b0, 1'b0);
        start(3'b011, 8'hF0, 8'h0C);
        tick();
        check_done("or", 8'hFC, 1'b0, 1'b0);
        start(3'b100, 8'h5A, 8'h5A);
        tick();
        check_done("xor", 8'h00, 1'b0, 1'b1);
        start(3'b101, 8'h01, 8'h0F);
        tick();
        check_done("shl_msk", 8'h80, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
